// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - frame_state_t : states of the serial frame FSM
//   - SC_E0 / SC_F0 : extended and break prefix bytes (scan-code set 2)
//   - SC_* / HID_*  : set-2 scan codes and USB HID usage codes of the mapped keys
//   - map_key()     : translates {ext, scan code} to {hit, HID code}
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_t;

   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_F0 = 8'hF0;

   localparam logic [7:0] SC_W      = 8'h1D;
   localparam logic [7:0] SC_A      = 8'h1C;
   localparam logic [7:0] SC_S      = 8'h1B;
   localparam logic [7:0] SC_D      = 8'h23;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_X      = 8'h22;
   localparam logic [7:0] SC_ESC    = 8'h76;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_RIGHT  = 8'h74;

   localparam logic [7:0] HID_W      = 8'h1A;
   localparam logic [7:0] HID_A      = 8'h04;
   localparam logic [7:0] HID_S      = 8'h16;
   localparam logic [7:0] HID_D      = 8'h07;
   localparam logic [7:0] HID_ENTER  = 8'h28;
   localparam logic [7:0] HID_X      = 8'h1B;
   localparam logic [7:0] HID_ESC    = 8'h29;
   localparam logic [7:0] HID_LSHIFT = 8'hE1;
   localparam logic [7:0] HID_UP     = 8'h52;
   localparam logic [7:0] HID_DOWN   = 8'h51;
   localparam logic [7:0] HID_LEFT   = 8'h50;
   localparam logic [7:0] HID_RIGHT  = 8'h4F;

   // Bit 8 of the result flags a mapped key; unmapped codes return all zeros.
   function automatic logic [8:0] map_key(input logic ext, input logic [7:0] code);
      logic [8:0] r;
      r = '0;
      if (ext) begin
         case (code)
            SC_UP:    r = {1'b1, HID_UP};
            SC_DOWN:  r = {1'b1, HID_DOWN};
            SC_LEFT:  r = {1'b1, HID_LEFT};
            SC_RIGHT: r = {1'b1, HID_RIGHT};
            default:  r = '0;
         endcase
      end else begin
         case (code)
            SC_W:      r = {1'b1, HID_W};
            SC_A:      r = {1'b1, HID_A};
            SC_S:      r = {1'b1, HID_S};
            SC_D:      r = {1'b1, HID_D};
            SC_ENTER:  r = {1'b1, HID_ENTER};
            SC_X:      r = {1'b1, HID_X};
            SC_ESC:    r = {1'b1, HID_ESC};
            SC_LSHIFT: r = {1'b1, HID_LSHIFT};
            default:   r = '0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_keycode_rx_sync_filter.sv
// ps2_sync_filter
// Two-flop synchronizer, level filter and falling-edge detect for the PS/2 clock pin.
//   Clk   : system clock
//   Reset : synchronous active-low reset (filter comes up at the idle level 1)
//   pin   : raw asynchronous pin
//   fall  : one-cycle pulse when the filtered level goes 1 -> 0
module ps2_sync_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic pin,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          meta;
   logic          sync;
   logic          level;
   logic [CW-1:0] cnt;

   // The filtered level only follows the synchronized pin after FILTER_LEN
   // consecutive samples that disagree with it; any agreeing sample restarts
   // the count, so short glitches never reach the frame logic.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         meta  <= 1'b1;
         sync  <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         meta <= pin;
         sync <= meta;
         fall <= 1'b0;
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync;
            cnt   <= '0;
            fall  <= level;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
// PS/2 keyboard receiver: frames set-2 scan codes, tracks E0/F0 prefixes and
// keeps the HID code of the most recently pressed mapped key.
//   Clk       : system clock
//   Reset     : synchronous active-low reset
//   PS2_CLK   : keyboard clock pin (asynchronous)
//   PS2_DAT   : keyboard data pin (asynchronous)
//   keycode   : HID code of the held key, 8'h00 when none
//   key_event : one-cycle pulse whenever keycode changes
//   frame_err : one-cycle pulse when a frame is discarded
module ps2_keycode_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] keycode,
   output logic       key_event,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   frame_state_t  state;
   frame_state_t  state_next;
   logic          fall;
   logic          dat_meta;
   logic          dat;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_ok;
   logic [TW-1:0] tcnt;
   logic          timeout;
   logic          start_err;
   logic          stop_bad;
   logic          byte_done;
   logic          byte_valid;
   logic          ext;
   logic          brk;
   logic [8:0]    lookup;

   ps2_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .Clk   (Clk),
      .Reset (Reset),
      .pin   (PS2_CLK),
      .fall  (fall)
   );

   // Frame state register.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a timeout outranks everything else outside IDLE.
   always_comb begin
      state_next = state;
      if (timeout) begin
         state_next = ST_IDLE;
      end else if (fall) begin
         case (state)
            ST_IDLE:   if (!dat) state_next = ST_DATA;
            ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
            ST_PARITY: state_next = ST_STOP;
            ST_STOP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
         endcase
      end
   end

   // Frame outcome strobes, registered one cycle later as frame_err/byte_valid.
   always_comb begin
      timeout   = 1'b0;
      start_err = 1'b0;
      stop_bad  = 1'b0;
      byte_done = 1'b0;
      if (state != ST_IDLE && !fall && tcnt >= TW'(TIMEOUT_CYCLES - 1)) begin
         timeout = 1'b1;
      end
      if (fall) begin
         case (state)
            ST_IDLE: start_err = dat;
            ST_STOP: begin
               byte_done = dat & par_ok;
               stop_bad  = ~(dat & par_ok);
            end
            default: ;
         endcase
      end
   end

   // Data synchronizer, shift register, parity capture and the saturating
   // idle counter. The shift register is left untouched after the stop bit,
   // so it still holds the accepted byte while byte_valid is high.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         dat_meta   <= 1'b1;
         dat        <= 1'b1;
         bit_cnt    <= '0;
         shift      <= '0;
         par_ok     <= 1'b0;
         tcnt       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         dat_meta   <= PS2_DAT;
         dat        <= dat_meta;
         frame_err  <= start_err | stop_bad | timeout;
         byte_valid <= byte_done;
         if (fall) begin
            tcnt <= '0;
         end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
            tcnt <= tcnt + TW'(1);
         end
         if (state == ST_IDLE) begin
            bit_cnt <= '0;
         end else if (fall && state == ST_DATA) begin
            shift   <= {dat, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (fall && state == ST_PARITY) begin
            par_ok <= ^{shift, dat};
         end
      end
   end

   assign lookup = map_key(ext, shift);

   // Prefix tracking and key update. A break only releases the key that is
   // currently shown; a make equal to the current code is a typematic repeat
   // and produces no event.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         ext       <= 1'b0;
         brk       <= 1'b0;
         keycode   <= 8'h00;
         key_event <= 1'b0;
      end else begin
         key_event <= 1'b0;
         if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_valid) begin
            if (shift == SC_E0) begin
               ext <= 1'b1;
            end else if (shift == SC_F0) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (lookup[8]) begin
                  if (brk) begin
                     if (keycode == lookup[7:0]) begin
                        keycode   <= 8'h00;
                        key_event <= 1'b1;
                     end
                  end else if (keycode != lookup[7:0]) begin
                     keycode   <= lookup[7:0];
                     key_event <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule
